// File: rtl/sram_bist_pkg.sv
// Shared types and march-element tables for the SRAM March C- BIST sequencer.
package sram_bist_pkg;

  localparam int unsigned ELEM_W = 3;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // March element indices
  localparam logic [ELEM_W-1:0] M0 = 3'd0;
  localparam logic [ELEM_W-1:0] M1 = 3'd1;
  localparam logic [ELEM_W-1:0] M2 = 3'd2;
  localparam logic [ELEM_W-1:0] M3 = 3'd3;
  localparam logic [ELEM_W-1:0] M4 = 3'd4;
  localparam logic [ELEM_W-1:0] M5 = 3'd5;

  // Per-element description: direction, read+write pair, write-only, patterns
  typedef struct packed {
    logic up;      // 1: addresses 0..N-1, 0: N-1..0
    logic rw;      // 1: read then write per address (2 ops)
    logic has_wr;  // single-op element is a write
    logic rd_pat;  // expected read pattern bit (D0/D1)
    logic wr_pat;  // write pattern bit (D0/D1)
  } elem_cfg_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
  function automatic elem_cfg_t elem_cfg(input logic [ELEM_W-1:0] e);
    elem_cfg_t c;
    c = '{up: 1'b1, rw: 1'b0, has_wr: 1'b0, rd_pat: 1'b0, wr_pat: 1'b0};
    case (e)
      M0:      c = '{up: 1'b1, rw: 1'b0, has_wr: 1'b1, rd_pat: 1'b0, wr_pat: 1'b0};
      M1:      c = '{up: 1'b1, rw: 1'b1, has_wr: 1'b1, rd_pat: 1'b0, wr_pat: 1'b1};
      M2:      c = '{up: 1'b1, rw: 1'b1, has_wr: 1'b1, rd_pat: 1'b1, wr_pat: 1'b0};
      M3:      c = '{up: 1'b0, rw: 1'b1, has_wr: 1'b1, rd_pat: 1'b0, wr_pat: 1'b1};
      M4:      c = '{up: 1'b0, rw: 1'b1, has_wr: 1'b1, rd_pat: 1'b1, wr_pat: 1'b0};
      M5:      c = '{up: 1'b0, rw: 1'b0, has_wr: 1'b0, rd_pat: 1'b0, wr_pat: 1'b0};
      default: c = '{up: 1'b1, rw: 1'b0, has_wr: 1'b0, rd_pat: 1'b0, wr_pat: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// One-cycle read-compare pipeline with sticky fail flag and first-fail address latch.
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rdata,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);

  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

  // Capture the read in flight, then compare against returning data one cycle later
  always_comb begin
    cmp_vld_d   = rd_vld && !clr;
    exp_d       = rd_exp;
    cmp_addr_d  = rd_addr;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    if (clr) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
    end else if (cmp_vld_q && (rdata != exp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = cmp_addr_q;
    end
  end

  // Pipeline and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST sequencer driving the SRAM core port; reports done/fail on the BIST pins.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic                bist_clk,
  input  logic                bist_reset_n,
  input  logic                bist_ten,
  output logic                bist_done,
  output logic                bist_fail,
  output logic [ADDR_W-1:0]   bist_fail_addr,
  output logic                sram_wen,
  output logic [DATA_W/8-1:0] sram_ByteEna,
  output logic [ADDR_W-1:0]   sram_Addr,
  output logic [DATA_W-1:0]   sram_Wdata,
  input  logic [DATA_W-1:0]   sram_Rdata
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;

  logic                sram_wen_q, sram_wen_d;
  logic [BE_W-1:0]     sram_be_q, sram_be_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_exp_q, rd_exp_d;
  logic                bist_done_q, bist_done_d;

  elem_cfg_t cfg, cfg_nxt;
  logic      last_addr, last_op, op_act, op_wr, cmp_clr;

  assign cfg       = elem_cfg(elem_q);
  assign cfg_nxt   = elem_cfg(elem_q + 3'd1);
  assign last_addr = cfg.up ? (addr_q == ADDR_MAX) : (addr_q == '0);
  assign last_op   = cfg.rw ? phase_q : 1'b1;
  assign op_act    = (state_q == ST_RUN) && bist_ten;
  assign op_wr     = cfg.rw ? phase_q : cfg.has_wr;
  assign cmp_clr   = !bist_ten || (state_q == ST_IDLE);

  // State and counter registers
  always_ff @(posedge bist_clk or negedge bist_reset_n) begin
    if (!bist_reset_n) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // Next state: walk phase, address, then element; end of M5 flushes the last compare
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        elem_d  = '0;
        addr_d  = '0;
        phase_d = 1'b0;
        if (bist_ten) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bist_ten) begin
          state_d = ST_IDLE;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
        end else if (!last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = cfg.up ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
          end else if (elem_q == M5) begin
            state_d = ST_FLUSH;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = cfg_nxt.up ? '0 : ADDR_MAX;
          end
        end
      end
      ST_FLUSH: state_d = bist_ten ? ST_DONE : ST_IDLE;
      ST_DONE:  if (!bist_ten) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Port and status values for the next cycle; idle whenever not actively running
  always_comb begin
    sram_wen_d   = 1'b0;
    sram_be_d    = '0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    rd_vld_d     = 1'b0;
    rd_exp_d     = '0;
    bist_done_d  = (state_q == ST_DONE) && bist_ten;
    if (op_act) begin
      sram_be_d    = '1;
      sram_addr_d  = addr_q;
      sram_wen_d   = op_wr;
      sram_wdata_d = op_wr ? {DATA_W{cfg.wr_pat}} : '0;
      rd_vld_d     = !op_wr;
      rd_exp_d     = {DATA_W{cfg.rd_pat}};
    end
  end

  // Registered port outputs
  always_ff @(posedge bist_clk or negedge bist_reset_n) begin
    if (!bist_reset_n) begin
      sram_wen_q   <= 1'b0;
      sram_be_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rd_vld_q     <= 1'b0;
      rd_exp_q     <= '0;
      bist_done_q  <= 1'b0;
    end else begin
      sram_wen_q   <= sram_wen_d;
      sram_be_q    <= sram_be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rd_vld_q     <= rd_vld_d;
      rd_exp_q     <= rd_exp_d;
      bist_done_q  <= bist_done_d;
    end
  end

  sram_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk      (bist_clk),
    .rst_n    (bist_reset_n),
    .clr      (cmp_clr),
    .rd_vld   (rd_vld_q),
    .rd_exp   (rd_exp_q),
    .rd_addr  (sram_addr_q),
    .rdata    (sram_Rdata),
    .fail     (bist_fail),
    .fail_addr(bist_fail_addr)
  );

  assign bist_done    = bist_done_q;
  assign sram_wen     = sram_wen_q;
  assign sram_ByteEna = sram_be_q;
  assign sram_Addr    = sram_addr_q;
  assign sram_Wdata   = sram_wdata_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed + randomized bench for sram_bist_ctrl with a faultable 1-cycle-latency SRAM model.
module tb_sram_bist_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 16;

  typedef logic [40:0] op_t; // {ByteEna, wen, addr, data}

  logic          clk;
  logic          rst_n;
  logic          ten;
  logic          bist_done;
  logic          bist_fail;
  logic [AW-1:0] bist_fail_addr;
  logic          sram_wen;
  logic [3:0]    sram_ByteEna;
  logic [AW-1:0] sram_Addr;
  logic [DW-1:0] sram_Wdata;
  logic [DW-1:0] sram_Rdata;

  int errors = 0;
  int checks = 0;
  int fault_mode = 0; // 0 none, 1 stuck-at-1 bit3 @5, 2 write@2 flips bit0 @9
  int done_c;
  op_t exp_q[$];
  op_t obs_q[$];

  // March C- as a table: 0 none, 1 r0, 2 r1, 3 w0, 4 w1
  int el_up [6]    = '{1, 1, 1, 0, 0, 0};
  int el_ops[6][2] = '{'{3, 0}, '{1, 4}, '{2, 3}, '{1, 4}, '{2, 3}, '{1, 0}};

  logic [DW-1:0] mem [N];

  sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .bist_clk      (clk),
    .bist_reset_n  (rst_n),
    .bist_ten      (ten),
    .bist_done     (bist_done),
    .bist_fail     (bist_fail),
    .bist_fail_addr(bist_fail_addr),
    .sram_wen      (sram_wen),
    .sram_ByteEna  (sram_ByteEna),
    .sram_Addr     (sram_Addr),
    .sram_Wdata    (sram_Wdata),
    .sram_Rdata    (sram_Rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with optional injected faults
  always @(posedge clk) begin
    if (sram_wen && sram_ByteEna == 4'hF) begin
      mem[sram_Addr] <= sram_Wdata;
      if (fault_mode == 2 && sram_Addr == 4'd2) mem[9][0] <= ~mem[9][0];
    end
    sram_Rdata <= mem[sram_Addr] | ((fault_mode == 1 && sram_Addr == 4'd5) ? 32'h8 : 32'h0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected port op stream from the march table
  task automatic build_exp();
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < int'(N); k++)
        for (int p = 0; p < 2; p++) begin
          int op;
          logic [3:0] a;
          op = el_ops[e][p];
          a  = 4'((el_up[e] != 0) ? k : int'(N) - 1 - k);
          if (op >= 3) exp_q.push_back({4'hF, 1'b1, a, (op == 4) ? 32'hFFFF_FFFF : 32'h0});
          else if (op != 0) exp_q.push_back({4'hF, 1'b0, a, 32'h0});
        end
  endtask

  // Replay the march on an abstract faulty memory to find the first miscompare
  function automatic void model_fail(input int fm, output logic f, output logic [3:0] fa);
    logic [31:0] rm [16];
    f  = 1'b0;
    fa = '0;
    for (int i = 0; i < 16; i++) rm[i] = 32'($urandom);
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < 16; k++)
        for (int p = 0; p < 2; p++) begin
          int op;
          int a;
          logic [31:0] rd;
          logic [31:0] ev;
          op = el_ops[e][p];
          a  = (el_up[e] != 0) ? k : 15 - k;
          if (op >= 3) begin
            rm[a] = (op == 4) ? 32'hFFFF_FFFF : 32'h0;
            if (fm == 2 && a == 2) rm[9][0] = ~rm[9][0];
          end else if (op != 0) begin
            rd = rm[a] | ((fm == 1 && a == 5) ? 32'h8 : 32'h0);
            ev = (op == 2) ? 32'hFFFF_FFFF : 32'h0;
            if (rd != ev && !f) begin
              f  = 1'b1;
              fa = 4'(a);
            end
          end
        end
  endfunction

  // Hold ten high and record port ops until done, stop_c, or the cycle budget
  task automatic run_march(input int stop_c);
    obs_q.delete();
    done_c = -1;
    ten = 1'b1;
    for (int c = 0; c <= 200; c++) begin
      tick();
      if (sram_ByteEna != 4'h0)
        obs_q.push_back({sram_ByteEna, sram_wen, sram_Addr, sram_wen ? sram_Wdata : 32'h0});
      if (bist_done) begin
        done_c = c;
        break;
      end
      if (c == stop_c) break;
    end
  endtask

  task automatic check_run(input string tag, input int fm);
    logic       f;
    logic [3:0] fa;
    model_fail(fm, f, fa);
    chk({tag, ".done_cycle"}, 64'(done_c), 64'(162));
    chk({tag, ".fail"}, 64'(bist_fail), 64'(f));
    chk({tag, ".fail_addr"}, 64'(bist_fail_addr), 64'(fa));
    chk({tag, ".op_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s.op%0d", tag, i), 64'((i < obs_q.size()) ? obs_q[i] : '0), 64'(exp_q[i]));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".wen"}, 64'(sram_wen), 64'(0));
    chk({tag, ".be"}, 64'(sram_ByteEna), 64'(0));
    chk({tag, ".addr"}, 64'(sram_Addr), 64'(0));
    chk({tag, ".wdata"}, 64'(sram_Wdata), 64'(0));
    chk({tag, ".done"}, 64'(bist_done), 64'(0));
    chk({tag, ".fail"}, 64'(bist_fail), 64'(0));
    chk({tag, ".fail_addr"}, 64'(bist_fail_addr), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    ten   = 1'b0;
    build_exp();
    repeat (3) tick();
    chk_idle_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Fault-free run
    fault_mode = 0;
    run_march(-1);
    check_run("clean", 0);
    ten = 1'b0;
    repeat (2) tick();

    // Stuck-at-1, then hold DONE with a latched failure
    fault_mode = 1;
    run_march(-1);
    check_run("stuck", 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk($sformatf("hold%0d", i), 64'({bist_done, bist_fail, bist_fail_addr, sram_wen, sram_ByteEna}),
          64'({1'b1, 1'b1, 4'd5, 1'b0, 4'h0}));
    end
    ten = 1'b0;
    tick();
    chk("hold.drop_done", 64'(bist_done), 64'(0));
    chk("hold.drop_fail", 64'(bist_fail), 64'(0));
    tick();

    // Coupling fault
    fault_mode = 2;
    run_march(-1);
    check_run("coupling", 2);
    ten = 1'b0;
    repeat (2) tick();

    // Abort inside M1, then a clean re-run
    fault_mode = 0;
    run_march(40);
    chk("abort.active", 64'(sram_ByteEna), 64'(4'hF));
    ten = 1'b0;
    tick();
    chk("abort.wen", 64'(sram_wen), 64'(0));
    chk("abort.be", 64'(sram_ByteEna), 64'(0));
    chk("abort.done", 64'(bist_done), 64'(0));
    chk("abort.fail", 64'(bist_fail), 64'(0));
    tick();
    chk("abort.still_idle", 64'(sram_ByteEna), 64'(0));
    run_march(-1);
    check_run("rerun", 0);
    ten = 1'b0;
    repeat (2) tick();

    // Async reset during an M3 write, restart with ten held
    run_march(86);
    chk("rst.m3_write", 64'(obs_q.size() > 0 ? obs_q[obs_q.size()-1] : '0), 64'(exp_q[85]));
    #2 rst_n = 1'b0;
    #1 chk_idle_zero("rst_async");
    repeat (2) tick();
    chk_idle_zero("rst_held");
    rst_n = 1'b1;
    run_march(-1);
    check_run("post_rst", 0);
    ten = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
